// File: rtl/cp0_intr_unit_pkg.sv
// Shared CP0 constants: EXE-stage oper encodings, CP0 register numbers and
// the interrupt responder state type.
package cp0_intr_unit_pkg;

    localparam logic [1:0] EXE_CP_NONE  = 2'd0;
    localparam logic [1:0] EXE_CP_STORE = 2'd1;
    localparam logic [1:0] EXE_CP0_ERET = 2'd2;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_EHBR  = 5'd25;

    localparam int CAUSE_PEND_BIT = 10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_intr_unit_if.sv
// Pipeline <-> CP0 bus. The pipeline (master) drives the EXE-stage operation;
// CP0 (slave) returns read data, the redirect and handler status.
interface cp0_intr_unit_if;
    import cp0_intr_unit_pkg::*;

    // exe_valid qualifies oper/pc_exe/addr_w/data_w for one cycle; there is no
    // ready: CP0 always accepts, and jump_en is a single-cycle redirect pulse.
    logic [1:0]  oper;
    logic        exe_valid;
    logic [31:0] pc_exe;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        in_handler;
    cp0_state_e  state_dbg;

    modport master (
        output oper, exe_valid, pc_exe, addr_r, addr_w, data_w,
        input  data_r, jump_en, jump_addr, in_handler, state_dbg
    );

    modport slave (
        input  oper, exe_valid, pc_exe, addr_r, addr_w, data_w,
        output data_r, jump_en, jump_addr, in_handler, state_dbg
    );

endinterface

// File: rtl/cp0_intr_unit_int_sync_edge.sv
// Multi-flop synchroniser for the asynchronous interrupt line followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module cp0_intr_unit_int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cp0_intr_unit.sv
// Coprocessor-0 register file and single-level interrupt responder: executes
// MTC0/MFC0/ERET for the EXE stage and redirects the pipeline on interrupt/return.
module cp0_intr_unit
    import cp0_intr_unit_pkg::*;
#(
    parameter logic [31:0] EHBR_RESET  = 32'h0000_0008,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_int,
    cp0_intr_unit_if.slave   bus
);

    cp0_state_e  state_q;
    logic        in_handler_q;
    logic        ie_q, ie_d;
    logic        pending_q, pending_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] ehbr_q, ehbr_d;

    logic int_rise;
    logic take_int;
    logic do_eret;
    logic wr_en;

    cp0_intr_unit_int_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ext_int),
        .rise_o  (int_rise)
    );

    // IE is sampled from the stored value, so an MTC0 clearing IE cannot
    // block an interrupt that is already qualifying in the same cycle.
    assign take_int = pending_q & ie_q & bus.exe_valid & (state_q == ST_IDLE)
                    & (bus.oper != EXE_CP0_ERET);
    assign do_eret  = bus.exe_valid & (bus.oper == EXE_CP0_ERET) & (state_q == ST_HANDLER);
    assign wr_en    = bus.exe_valid & (bus.oper == EXE_CP_STORE) & ~take_int;

    always_comb begin
        bus.jump_en   = take_int | do_eret;
        bus.jump_addr = 32'h0;
        if (take_int)
            bus.jump_addr = ehbr_q;
        else if (do_eret)
            bus.jump_addr = epc_q;
    end

    always_comb begin
        bus.data_r = 32'h0;
        case (bus.addr_r)
            CP0_SR:    bus.data_r = {31'h0, ie_q};
            CP0_CAUSE: bus.data_r[CAUSE_PEND_BIT] = pending_q;
            CP0_EPC:   bus.data_r = epc_q;
            CP0_EHBR:  bus.data_r = ehbr_q;
            default:   bus.data_r = 32'h0;
        endcase
    end

    always_comb begin
        ie_d      = ie_q;
        epc_d     = epc_q;
        ehbr_d    = ehbr_q;
        // A new edge landing in the clearing cycle must not be lost.
        pending_d = int_rise | (pending_q & ~take_int);
        if (take_int) begin
            epc_d = bus.pc_exe;
        end else if (wr_en) begin
            case (bus.addr_w)
                CP0_SR:   ie_d   = bus.data_w[0];
                CP0_EPC:  epc_d  = bus.data_w;
                CP0_EHBR: ehbr_d = bus.data_w;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q      <= 1'b0;
            pending_q <= 1'b0;
            epc_q     <= 32'h0;
            ehbr_q    <= EHBR_RESET;
        end else begin
            ie_q      <= ie_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
            ehbr_q    <= ehbr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_handler_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_int) begin
                        state_q      <= ST_HANDLER;
                        in_handler_q <= 1'b1;
                    end
                end
                ST_HANDLER: begin
                    if (do_eret) begin
                        state_q      <= ST_IDLE;
                        in_handler_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    in_handler_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_handler = in_handler_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_cp0_intr_unit.sv
// Directed bench for cp0_intr_unit: MTC0/MFC0/ERET, interrupt capture latency,
// same-cycle collisions, EHBR relocation and asynchronous reset.
module tb_cp0_intr_unit;
    import cp0_intr_unit_pkg::*;

    logic clk;
    logic rst;
    logic ext_int;
    int   checks;
    int   errors;

    cp0_intr_unit_if bus ();

    cp0_intr_unit #(
        .EHBR_RESET  (32'h0000_0008),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ext_int (ext_int),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] pc);
        bus.exe_valid = v;
        bus.oper      = op;
        bus.pc_exe    = pc;
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.addr_w = a;
        bus.data_w = d;
        drive(1'b1, EXE_CP_STORE, pc);
    endtask

    task automatic rd(input logic [4:0] a);
        bus.addr_r = a;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, EXE_CP_NONE, 32'h0);
    endtask

    // One-cycle ext_int pulse; pending is set after the third edge.
    task automatic pulse_int();
        ext_int = 1'b1;
        tick();
        ext_int = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ext_int = 1'b0;
        bus.oper = EXE_CP_NONE;
        bus.exe_valid = 1'b0;
        bus.pc_exe = 32'h0;
        bus.addr_r = 5'd0;
        bus.addr_w = 5'd0;
        bus.data_w = 32'h0;
        #1;
        chk("rst_in_handler", {31'h0, bus.in_handler}, 32'h0);
        chk("rst_jump_en", {31'h0, bus.jump_en}, 32'h0);
        rd(CP0_EPC);  chk("rst_epc", bus.data_r, 32'h0);
        rd(CP0_EHBR); chk("rst_ehbr", bus.data_r, 32'h8);
        rd(CP0_SR);   chk("rst_sr", bus.data_r, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Enable interrupts, then time pending capture.
        mtc0(CP0_SR, 32'h1, 32'h10);
        tick();
        idle();
        rd(CP0_SR); chk("sr_written", bus.data_r, 32'h1);
        ext_int = 1'b1;
        tick();
        ext_int = 1'b0;
        rd(CP0_CAUSE); chk("cause_1cyc", bus.data_r, 32'h0);
        tick();
        chk("cause_2cyc", bus.data_r, 32'h0);
        tick();
        chk("cause_3cyc", bus.data_r, 32'h400);

        // Take the interrupt.
        drive(1'b1, EXE_CP_NONE, 32'h100);
        chk("take_jump_en", {31'h0, bus.jump_en}, 32'h1);
        chk("take_jump_addr", bus.jump_addr, 32'h8);
        tick();
        idle();
        chk("take_in_handler", {31'h0, bus.in_handler}, 32'h1);
        chk("take_state", {31'h0, bus.state_dbg}, {31'h0, ST_HANDLER});
        rd(CP0_EPC);   chk("take_epc", bus.data_r, 32'h100);
        rd(CP0_CAUSE); chk("take_cause_clr", bus.data_r, 32'h0);

        // ERET, then ERET in IDLE is a no-op.
        drive(1'b1, EXE_CP0_ERET, 32'h10c);
        chk("eret_jump_en", {31'h0, bus.jump_en}, 32'h1);
        chk("eret_jump_addr", bus.jump_addr, 32'h100);
        tick();
        drive(1'b1, EXE_CP0_ERET, 32'h110);
        chk("eret_in_handler", {31'h0, bus.in_handler}, 32'h0);
        chk("eret_idle_jump_en", {31'h0, bus.jump_en}, 32'h0);
        chk("eret_idle_jump_addr", bus.jump_addr, 32'h0);
        tick();
        idle();
        chk("eret_idle_state", {31'h0, bus.in_handler}, 32'h0);

        // Interrupt masked by IE=0, then unmasked by MTC0.
        mtc0(CP0_SR, 32'h0, 32'h114);
        tick();
        idle();
        pulse_int();
        drive(1'b1, EXE_CP_NONE, 32'h120);
        chk("masked_jump_en", {31'h0, bus.jump_en}, 32'h0);
        rd(CP0_CAUSE); chk("masked_cause", bus.data_r, 32'h400);
        tick();
        mtc0(CP0_SR, 32'h1, 32'h124);
        chk("unmask_write_jump_en", {31'h0, bus.jump_en}, 32'h0);
        tick();
        drive(1'b1, EXE_CP_NONE, 32'h180);
        chk("unmask_jump_en", {31'h0, bus.jump_en}, 32'h1);
        chk("unmask_jump_addr", bus.jump_addr, 32'h8);
        tick();
        idle();
        chk("unmask_in_handler", {31'h0, bus.in_handler}, 32'h1);
        rd(CP0_EPC); chk("unmask_epc", bus.data_r, 32'h180);
        drive(1'b1, EXE_CP0_ERET, 32'h0);
        tick();
        idle();

        // Interrupt squashes a same-cycle MTC0 SR=0.
        pulse_int();
        mtc0(CP0_SR, 32'h0, 32'h300);
        chk("coll_jump_en", {31'h0, bus.jump_en}, 32'h1);
        chk("coll_jump_addr", bus.jump_addr, 32'h8);
        tick();
        idle();
        rd(CP0_SR);  chk("coll_sr_kept", bus.data_r, 32'h1);
        rd(CP0_EPC); chk("coll_epc", bus.data_r, 32'h300);

        // Pending held in HANDLER; ERET wins, interrupt follows.
        pulse_int();
        rd(CP0_CAUSE); chk("nest_cause", bus.data_r, 32'h400);
        drive(1'b1, EXE_CP_NONE, 32'h500);
        chk("nest_no_jump", {31'h0, bus.jump_en}, 32'h0);
        tick();
        drive(1'b1, EXE_CP0_ERET, 32'h504);
        chk("eret_pend_jump_en", {31'h0, bus.jump_en}, 32'h1);
        chk("eret_pend_jump_addr", bus.jump_addr, 32'h300);
        tick();
        drive(1'b1, EXE_CP_NONE, 32'h304);
        chk("eret_pend_idle", {31'h0, bus.in_handler}, 32'h0);
        chk("after_eret_jump_en", {31'h0, bus.jump_en}, 32'h1);
        chk("after_eret_jump_addr", bus.jump_addr, 32'h8);
        tick();
        idle();
        chk("after_eret_in_handler", {31'h0, bus.in_handler}, 32'h1);
        drive(1'b1, EXE_CP0_ERET, 32'h0);
        tick();
        idle();

        // New edge in the same cycle pending is cleared keeps it set.
        pulse_int();
        ext_int = 1'b1;
        tick();
        ext_int = 1'b0;
        tick();
        drive(1'b1, EXE_CP_NONE, 32'h600);
        chk("clr_edge_jump_en", {31'h0, bus.jump_en}, 32'h1);
        tick();
        idle();
        rd(CP0_CAUSE); chk("clr_edge_pending", bus.data_r, 32'h400);
        drive(1'b1, EXE_CP0_ERET, 32'h0);
        tick();
        drive(1'b1, EXE_CP_NONE, 32'h604);
        chk("clr_edge_retake", {31'h0, bus.jump_en}, 32'h1);
        tick();
        drive(1'b1, EXE_CP0_ERET, 32'h0);
        tick();
        idle();

        // EHBR write has no read bypass, then relocates the handler.
        bus.addr_r = CP0_EHBR;
        mtc0(CP0_EHBR, 32'h200, 32'h700);
        chk("ehbr_old", bus.data_r, 32'h8);
        tick();
        idle();
        chk("ehbr_new", bus.data_r, 32'h200);
        pulse_int();
        drive(1'b1, EXE_CP_NONE, 32'h400);
        chk("ehbr_jump_addr", bus.jump_addr, 32'h200);
        tick();

        // CAUSE is read-only, unmapped reads 0, MTC0 EPC retargets ERET.
        mtc0(CP0_CAUSE, 32'hffff_ffff, 32'h0);
        tick();
        mtc0(CP0_EPC, 32'h444, 32'h0);
        tick();
        idle();
        rd(CP0_CAUSE); chk("cause_ro", bus.data_r, 32'h0);
        rd(5'd5);      chk("unmapped", bus.data_r, 32'h0);
        drive(1'b1, EXE_CP0_ERET, 32'h0);
        chk("new_epc_jump_addr", bus.jump_addr, 32'h444);
        tick();
        idle();
        chk("new_epc_idle", {31'h0, bus.in_handler}, 32'h0);

        // Asynchronous reset while in HANDLER with EPC = 0x40.
        pulse_int();
        drive(1'b1, EXE_CP_NONE, 32'h800);
        tick();
        mtc0(CP0_EPC, 32'h40, 32'h0);
        tick();
        idle();
        rd(CP0_EPC); chk("pre_rst_epc", bus.data_r, 32'h40);
        chk("pre_rst_in_handler", {31'h0, bus.in_handler}, 32'h1);
        drive(1'b1, EXE_CP0_ERET, 32'h0);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_handler", {31'h0, bus.in_handler}, 32'h0);
        chk("mid_rst_jump_en", {31'h0, bus.jump_en}, 32'h0);
        rd(CP0_EPC);  chk("mid_rst_epc", bus.data_r, 32'h0);
        rd(CP0_EHBR); chk("mid_rst_ehbr", bus.data_r, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
